// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage
//   Front end that owns the PC, reads 16-bit words from a combinational-read
//   instruction memory, stitches two-word (immediate) instructions together
//   and drives the IF/ID register feeding the register file.
//
// Parameters
//   ADDR_W    width of the PC / instruction memory address
//   RESET_PC  PC loaded on reset
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   imem_addr           instruction address (combinational copy of pc)
//   imem_rdata          instruction word at imem_addr, same cycle
//   stall               freeze fetch and hold IF/ID
//   redirect_valid/_pc  load a new pc and squash any half-assembled instruction
//   opcode, read_addr1, read_addr2, imm, dec_valid, dec_pc
//                       registered IF/ID contents
//
// Optional build macro FETCH_PERF_CNT_EN adds two 32-bit outputs:
//   instr_count   edges that issued a valid instruction
//   bubble_count  edges that loaded a bubble (two-word first fetch or redirect)
module fetch_decode_stage #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [4:0]        opcode,
  output logic [2:0]        read_addr1,
  output logic [2:0]        read_addr2,
  output logic [15:0]       imm,
  output logic              dec_valid,
  output logic [ADDR_W-1:0] dec_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       instr_count,
  output logic [31:0]       bubble_count
`endif
);

  typedef enum logic {
    FETCH_OP  = 1'b0,
    FETCH_IMM = 1'b1
  } state_t;

  function automatic logic is_two_word(input logic [4:0] op);
    return (op == 5'd24) || (op == 5'd25) || (op == 5'd26);
  endfunction

  state_t state, state_nxt;

  // Fetch stage state (p0): pc and the held first word of a two-word instruction.
  // Only bits [15:5] of the first word (opcode and register fields) are kept.
  logic [ADDR_W-1:0] pc_p0, pc_nxt;
  logic [15:5]       hold_p0, hold_nxt;
  logic [ADDR_W-1:0] hold_pc_p0, hold_pc_nxt;

  // IF/ID register (p1).
  logic [4:0]        opcode_p1, opcode_nxt;
  logic [2:0]        ra1_p1, ra1_nxt;
  logic [2:0]        ra2_p1, ra2_nxt;
  logic [15:0]       imm_p1, imm_nxt;
  logic              vld_p1, vld_nxt;
  logic [ADDR_W-1:0] dec_pc_p1, dec_pc_nxt;

  logic issue;
  logic bubble;

  assign imem_addr  = pc_p0;
  assign opcode     = opcode_p1;
  assign read_addr1 = ra1_p1;
  assign read_addr2 = ra2_p1;
  assign imm        = imm_p1;
  assign dec_valid  = vld_p1;
  assign dec_pc     = dec_pc_p1;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_p0;
    hold_nxt    = hold_p0;
    hold_pc_nxt = hold_pc_p0;
    opcode_nxt  = opcode_p1;
    ra1_nxt     = ra1_p1;
    ra2_nxt     = ra2_p1;
    imm_nxt     = imm_p1;
    vld_nxt     = vld_p1;
    dec_pc_nxt  = dec_pc_p1;
    issue       = 1'b0;
    bubble      = 1'b0;

    if (redirect_valid) begin
      // Redirect overrides stall: the half-assembled instruction is dropped.
      pc_nxt      = redirect_pc;
      state_nxt   = FETCH_OP;
      hold_nxt    = '0;
      hold_pc_nxt = '0;
      opcode_nxt  = '0;
      ra1_nxt     = '0;
      ra2_nxt     = '0;
      imm_nxt     = '0;
      vld_nxt     = 1'b0;
      bubble      = 1'b1;
    end else if (!stall) begin
      pc_nxt = pc_p0 + ADDR_W'(1);
      case (state)
        FETCH_OP: begin
          if (is_two_word(imem_rdata[15:11])) begin
            hold_nxt    = imem_rdata[15:5];
            hold_pc_nxt = pc_p0;
            opcode_nxt  = '0;
            ra1_nxt     = '0;
            ra2_nxt     = '0;
            imm_nxt     = '0;
            vld_nxt     = 1'b0;
            state_nxt   = FETCH_IMM;
            bubble      = 1'b1;
          end else begin
            opcode_nxt = imem_rdata[15:11];
            ra1_nxt    = imem_rdata[10:8];
            ra2_nxt    = imem_rdata[7:5];
            imm_nxt    = '0;
            vld_nxt    = 1'b1;
            dec_pc_nxt = pc_p0;
            issue      = 1'b1;
          end
        end
        FETCH_IMM: begin
          opcode_nxt = hold_p0[15:11];
          ra1_nxt    = hold_p0[10:8];
          ra2_nxt    = hold_p0[7:5];
          imm_nxt    = imem_rdata;
          vld_nxt    = 1'b1;
          dec_pc_nxt = hold_pc_p0;
          state_nxt  = FETCH_OP;
          issue      = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH_OP;
      pc_p0      <= RESET_PC;
      hold_p0    <= '0;
      hold_pc_p0 <= '0;
      opcode_p1  <= '0;
      ra1_p1     <= '0;
      ra2_p1     <= '0;
      imm_p1     <= '0;
      vld_p1     <= 1'b0;
      dec_pc_p1  <= '0;
    end else begin
      state      <= state_nxt;
      pc_p0      <= pc_nxt;
      hold_p0    <= hold_nxt;
      hold_pc_p0 <= hold_pc_nxt;
      opcode_p1  <= opcode_nxt;
      ra1_p1     <= ra1_nxt;
      ra2_p1     <= ra2_nxt;
      imm_p1     <= imm_nxt;
      vld_p1     <= vld_nxt;
      dec_pc_p1  <= dec_pc_nxt;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (issue)  instr_count  <= instr_count + 32'd1;
      if (bubble) bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Front-end stage directly upstream of the register file.
- Owns the PC and fetches 16-bit instruction words from a combinational-read instruction memory.
- Assembles two-word (immediate) instructions and drives the IF/ID pipeline register that supplies opcode, read_addr1 and read_addr2 to the register file.
- Handles stall from hazard logic and PC redirect from branch/execute.

Parameters:
- ADDR_W, 16, width of PC and instruction memory address.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  ADDR_W  instruction memory address; combinationally equal to pc.
- imem_rdata  input  16  instruction word at imem_addr, valid in the same cycle.
- stall  input  1  freeze fetch and hold the IF/ID outputs.
- redirect_valid  input  1  load redirect_pc and squash the in-flight fetch.
- redirect_pc  input  ADDR_W  redirect target.
- opcode  output  5  decoded opcode (instr[15:11]); 0 = NOP.
- read_addr1  output  3  instr[10:8].
- read_addr2  output  3  instr[7:5].
- imm  output  16  immediate word for two-word instructions, else 0.
- dec_valid  output  1  IF/ID holds a real instruction.
- dec_pc  output  ADDR_W  address of the first word of the instruction in IF/ID.

Behaviour:
- Priority each edge: reset > redirect_valid > stall > normal fetch.
- Reset:
  - pc=RESET_PC, state=FETCH_OP.
  - opcode, read_addr1, read_addr2, imm, dec_pc = 0; dec_valid=0.
  - hold register = 0.
- Two-word opcodes are exactly 24, 25, 26. All other opcodes are single-word.
- State FETCH_OP, no stall:
  - Single-word: IF/ID <= fields of imem_rdata; imm=0; dec_valid=1; dec_pc=pc; pc<=pc+1.
  - Two-word: hold <= imem_rdata, hold_pc <= pc; pc<=pc+1; IF/ID <= bubble (opcode=0, regs=0, imm=0, dec_valid=0); go FETCH_IMM.
- State FETCH_IMM, no stall:
  - IF/ID <= fields of hold; imm <= imem_rdata; dec_pc <= hold_pc; dec_valid=1.
  - pc<=pc+1; go FETCH_OP.
- Stall: pc, state, hold and all IF/ID outputs unchanged.
- Redirect (regardless of stall or state):
  - pc <= redirect_pc; state <= FETCH_OP; hold discarded.
  - IF/ID <= bubble.
- Latency: a single-word instruction presented at pc in cycle N appears on the outputs after edge N (one cycle). A two-word instruction appears one edge after its immediate word is fetched.
- pc arithmetic is modulo 2^ADDR_W: 16'hFFFF+1 = 0. A two-word instruction whose first word is at the top address takes its immediate from address 0.
- Reset mid-instruction (in FETCH_IMM) abandons the held word; no partial instruction is ever issued.
- imem_addr is purely combinational from pc. No other output is combinational.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - instr_count (32 bits): increments on every edge that sets dec_valid=1.
  - bubble_count (32 bits): increments on every edge that loads a bubble (two-word first fetch or redirect). Stall edges do not increment it.
  - Both counters reset to 0 on reset and wrap at 2^32.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset → imem_addr=0, opcode=0, dec_valid=0, imm=0; held reset for 3 cycles keeps these values.
- Straight line, imem[0]=16'h1920 (opc 3, r1=1, r2=1), imem[1]=16'h0000 → edge 1: opcode=3, read_addr1=1, dec_pc=0, dec_valid=1; edge 2: opcode=0, dec_pc=1.
- Two-word, imem[0]=16'hC200 (opc 24, r1=2), imem[1]=16'h1234 → edge 1: dec_valid=0; edge 2: opcode=24, read_addr1=2, imm=16'h1234, dec_pc=0, dec_valid=1; pc=2.
- Stall asserted for 2 cycles after edge 1 of the previous case → outputs and pc=1 frozen; the instruction completes one edge after stall drops.
- redirect_valid with redirect_pc=16'h0040 while in FETCH_IMM and stall=1 → next edge pc=16'h0040, dec_valid=0, state FETCH_OP; the following edge issues imem[16'h40].
- pc=16'hFFFF with a two-word opcode at 16'hFFFF and imm at 0 → imm=imem[0], dec_pc=16'hFFFF, pc=1. With FETCH_PERF_CNT_EN: instr_count=1, bubble_count=1.
